// File: rtl/bus_mux_pkg.sv
// Shared constants and helpers for the registered bus multiplexer.
// Arbitration mode encodings, default data width and a ceil-log2 helper.
// No logic, so no latency or backpressure of its own.
package bus_mux_pkg;

  localparam int ARB_DIRECT    = 0;
  localparam int ARB_RR        = 1;
  localparam int DEFAULT_WIDTH = 8;

  // Select width for n channels; a single channel still needs one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant picker: first requester above ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter  int N    = 2,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_ok
);

  int idx;

  // Walk the search order backwards so the nearest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_ok  = |req;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (idx == i && req[i]) gnt_idx = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// N-channel registered bus mux with direct-select or round-robin arbitration; BUS_MUX_LOCK_EN adds in_lock.
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle sustained.
// Backpressure: single output entry refills as it drains; a stalled entry blocks every in_ready.
module bus_mux_arb
  import bus_mux_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int N        = 2,
  parameter  int ARB_MODE = ARB_DIRECT,
  localparam int SELW     = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
`ifdef BUS_MUX_LOCK_EN
  ,
  input  logic [N-1:0]       in_lock
`endif
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;

  logic [SELW-1:0]  rr_idx;
  logic             rr_ok;
  logic [SELW-1:0]  g;
  logic             grant_ok;
  logic             dir_ok;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] g_data;

`ifdef BUS_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  owner_q, owner_d;
  logic             g_lock;
`endif

  rr_arbiter #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_ok  (rr_ok)
  );

  // A select value beyond the last channel matches nothing and grants nothing.
  always_comb begin
    dir_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) dir_ok = in_valid[i];
    end
    if (ARB_MODE == ARB_RR) begin
      g        = rr_idx;
      grant_ok = rr_ok;
    end else begin
      g        = sel;
      grant_ok = dir_ok;
    end
`ifdef BUS_MUX_LOCK_EN
    if (lock_q) begin
      g        = owner_q;
      grant_ok = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (owner_q == SELW'(i)) grant_ok = in_valid[i];
      end
    end
`endif
  end

  assign load = !out_valid_q || out_ready;
  assign xfer = load && grant_ok && !rst;

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) begin
        in_ready[i] = xfer;
        g_data      = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef BUS_MUX_LOCK_EN
  always_comb begin
    g_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) g_lock = in_lock[i];
    end
    lock_d  = lock_q;
    owner_d = owner_q;
    if (xfer) begin
      lock_d  = g_lock;
      owner_d = g;
    end
  end
`endif

  // Priority rotates only when a beat actually moves.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_chan_d  = g;
      ptr_d       = g;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SELW'(N - 1);
`ifdef BUS_MUX_LOCK_EN
      lock_q      <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
`ifdef BUS_MUX_LOCK_EN
      lock_q      <= lock_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Bench for bus_mux_arb: a 6-channel direct-select instance and a 4-channel round-robin instance
// driven side by side and compared every cycle against an integer-level model of the mux rules.
module tb_bus_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]  d_sel;
  logic [47:0] d_in_data;
  logic [5:0]  d_in_valid, d_in_ready;
  logic [7:0]  d_out_data;
  logic        d_out_valid, d_out_ready;
  logic [2:0]  d_out_chan;

  logic [1:0]  r_sel;
  logic [31:0] r_in_data;
  logic [3:0]  r_in_valid, r_in_ready, r_in_lock;
  logic [7:0]  r_out_data;
  logic        r_out_valid, r_out_ready;
  logic [1:0]  r_out_chan;

`ifdef BUS_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
  logic [5:0] d_in_lock;
  assign d_in_lock = '0;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  bus_mux_arb #(.WIDTH(8), .N(6), .ARB_MODE(0)) u_dir (
    .clk(clk), .rst(rst), .sel(d_sel), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_chan(d_out_chan)
`ifdef BUS_MUX_LOCK_EN
    , .in_lock(d_in_lock)
`endif
  );

  bus_mux_arb #(.WIDTH(8), .N(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .sel(r_sel), .in_data(r_in_data), .in_valid(r_in_valid),
    .in_ready(r_in_ready), .out_data(r_out_data), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_chan(r_out_chan)
`ifdef BUS_MUX_LOCK_EN
    , .in_lock(r_in_lock)
`endif
  );

  int checks   = 0;
  int failures = 0;

  bit         md_v, mr_v, ml_lock;
  logic [7:0] md_data, mr_data;
  int         md_chan, mr_chan, mr_last, ml_owner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before the call; returns at the following negedge.
  task automatic cycle();
    int dg, rg;
    bit dok, rok, dload, rload;
    logic [5:0] dexp;
    logic [3:0] rexp;
    #1;
    dload = !md_v || d_out_ready;
    dg    = int'(d_sel);
    dok   = (dg < 6) ? d_in_valid[dg] : 1'b0;
    dexp  = '0;
    if (!rst && dload && dok) dexp[dg] = 1'b1;

    rload = !mr_v || r_out_ready;
    rok   = 1'b0;
    rg    = 0;
    if (LOCK_EN && ml_lock) begin
      rg  = ml_owner;
      rok = r_in_valid[rg];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!rok && r_in_valid[(mr_last + k) % 4]) begin
          rok = 1'b1;
          rg  = (mr_last + k) % 4;
        end
      end
    end
    rexp = '0;
    if (!rst && rload && rok) rexp[rg] = 1'b1;

    chk("d_in_ready", 32'(d_in_ready), 32'(dexp));
    chk("r_in_ready", 32'(r_in_ready), 32'(rexp));

    @(posedge clk);
    if (rst) begin
      md_v = 1'b0; md_data = '0; md_chan = 0;
      mr_v = 1'b0; mr_data = '0; mr_chan = 0;
      mr_last = 3; ml_lock = 1'b0; ml_owner = 0;
    end else begin
      if (dload && dok) begin
        md_v = 1'b1; md_data = d_in_data[dg*8 +: 8]; md_chan = dg;
      end else if (dload) begin
        md_v = 1'b0;
      end
      if (rload && rok) begin
        mr_v = 1'b1; mr_data = r_in_data[rg*8 +: 8]; mr_chan = rg;
        mr_last = rg; ml_lock = LOCK_EN && r_in_lock[rg]; ml_owner = rg;
      end else if (rload) begin
        mr_v = 1'b0;
      end
    end
    #1;
    chk("d_out_valid", 32'(d_out_valid), 32'(md_v));
    chk("d_out_data",  32'(d_out_data),  32'(md_data));
    chk("d_out_chan",  32'(d_out_chan),  32'(md_chan));
    chk("r_out_valid", 32'(r_out_valid), 32'(mr_v));
    chk("r_out_data",  32'(r_out_data),  32'(mr_data));
    chk("r_out_chan",  32'(r_out_chan),  32'(mr_chan));
    @(negedge clk);
  endtask

  initial begin
    md_v = 1'b0; md_data = '0; md_chan = 0;
    mr_v = 1'b0; mr_data = '0; mr_chan = 0;
    mr_last = 3; ml_lock = 1'b0; ml_owner = 0;

    rst         = 1'b1;
    d_sel       = 3'd0;
    d_in_data   = 48'h665544A52211;
    d_in_valid  = 6'b111111;
    d_out_ready = 1'b1;
    r_sel       = 2'd0;
    r_in_data   = 32'h44332211;
    r_in_valid  = 4'b1111;
    r_in_lock   = 4'b0000;
    r_out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("rst_r_ready", 32'(r_in_ready), 32'h0);
      chk("rst_d_ready", 32'(d_in_ready), 32'h0);
      chk("rst_r_valid", 32'(r_out_valid), 32'h0);
      chk("rst_d_data",  32'(d_out_data),  32'h0);
    end

    rst   = 1'b0;
    d_sel = 3'd2;
    cycle();
    chk("first_rr_chan", 32'(r_out_chan), 32'd0);
    chk("dir_a5_data",   32'(d_out_data), 32'hA5);
    chk("dir_a5_chan",   32'(d_out_chan), 32'd2);

    // Select an out-of-service channel while round-robin keeps rotating.
    d_sel      = 3'd5;
    d_in_valid = 6'b011111;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("rr_rotate", 32'(r_out_chan), 32'(k % 4));
      if (k == 1) chk("dir_sel5_valid", 32'(d_out_valid), 32'h0);
    end

    r_in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_ch13", 32'(r_out_chan), (k % 2 == 1) ? 32'd3 : 32'd1);
    end

    // Backpressure: first beat 0x3C held while the consumer stalls.
    r_in_valid = 4'b1111;
    r_in_data  = 32'h4433223C;
    cycle();
    chk("bp_first", 32'(r_out_data), 32'h3C);
    r_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_data",  32'(r_out_data), 32'h3C);
      chk("bp_hold_ready", 32'(r_in_ready), 32'h0);
    end
    r_out_ready = 1'b1;
    cycle();
    chk("bp_release_chan", 32'(r_out_chan), 32'd1);
    chk("bp_release_data", 32'(r_out_data), 32'h22);

    r_in_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      r_in_data[7:0] = 8'(k);
      cycle();
      chk("tput_valid", 32'(r_out_valid), 32'h1);
      chk("tput_data",  32'(r_out_data),  32'(k));
    end
    r_in_valid = 4'b0000;
    cycle();
    chk("tput_drop", 32'(r_out_valid), 32'h0);

`ifdef BUS_MUX_LOCK_EN
    r_in_lock  = 4'b0100;
    r_in_valid = 4'b0100;
    cycle();
    chk("lock_b0", 32'(r_out_chan), 32'd2);
    r_in_valid = 4'b0111;
    cycle();
    chk("lock_b1", 32'(r_out_chan), 32'd2);
    r_in_lock = 4'b0000;
    cycle();
    chk("lock_b2", 32'(r_out_chan), 32'd2);
    cycle();
    chk("lock_after", 32'(r_out_chan), 32'd0);
    r_in_lock  = 4'b0100;
    r_in_valid = 4'b0100;
    cycle();
    chk("relock", 32'(r_out_chan), 32'd2);
    r_in_valid = 4'b0111;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("lock_rst_chan", 32'(r_out_chan), 32'd0);
    r_in_lock = 4'b0000;
`endif

    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      d_sel       = 3'($urandom_range(0, 7));
      d_in_data   = 48'({$urandom(), $urandom()});
      d_in_valid  = 6'($urandom());
      d_out_ready = ($urandom_range(0, 3) != 0);
      r_in_data   = $urandom();
      r_in_valid  = 4'($urandom());
      r_in_lock   = 4'($urandom());
      r_out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_mux_arb.md
Name: bus_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit registered bus multiplexer for the 8-bit datapath; next generation of the team's 2:1 combinational mux.
- Adds valid/ready handshakes on every input and on the output, a one-entry output register, and a selectable arbitration mode: direct select or round-robin.
- Sits between multiple bus sources (ALU, memory read, immediate, I/O) and a single consumer such as the register file write port or the bus driver.

Parameters:
- WIDTH, 8, data width in bits.
- N, 2, number of input channels; legal range 2..16.
- ARB_MODE, 0, 0 = direct (channel chosen by sel), 1 = round-robin.
- Derived localparam SELW = clog2(N), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- sel  in  SELW  channel select; used only when ARB_MODE=0.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel data valid.
- in_ready  out  N  per-channel accept; at most one bit high in any cycle.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_chan  out  SELW  channel index of the beat in out_data.
- in_lock  in  N  present only with BUS_MUX_LOCK_EN; see Optional Feature.

Behaviour:
- Reset, synchronous and active-high, applied on a clk edge with rst=1:
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer = N-1, so channel 0 has top priority after reset.
  - Lock flag cleared.
  - in_ready is forced to all-0 while rst=1.
- Reset mid-operation discards any held beat; no in_ready is issued during the reset cycle.
- load = !out_valid | out_ready. The output stage is a single entry that refills in the same cycle it drains.
- Grant g and grant_ok are combinational:
  - Direct mode: g = sel. grant_ok = (sel < N) & in_valid[sel]. If sel >= N, nothing is granted.
  - RR mode: g = first channel with in_valid set, searching upward from ptr+1 modulo N (wraps N-1 -> 0). grant_ok = any in_valid.
- in_ready[i] = load & grant_ok & (i==g). There is a combinational path from in_valid to in_ready; this is permitted.
- Transfer occurs when in_valid[g] & in_ready[g]. On the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- If load=1 and there is no transfer: out_valid <= 0 and out_data/out_chan hold their values.
- While out_valid & !out_ready, out_data and out_chan stay stable (no overwrite).
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat per cycle with out_ready held high.
- The RR pointer updates to g only on a transfer; a stall does not rotate priority.
- In direct mode, changing sel while stalled has no effect on the held beat.
- Width rules: no arithmetic on data; out_chan is zero-extended to SELW bits.

Optional Feature:
- Macro: BUS_MUX_LOCK_EN.
- With the macro defined:
  - The in_lock[N] port exists.
  - A transfer with in_lock[g]=1 sets the lock flag with owner g.
  - While locked, g is forced to the owner regardless of sel or RR, and no other channel gets in_ready.
  - A transfer with in_lock[g]=0 clears the flag.
  - rst clears the flag.
  - Purpose: multi-beat bus transactions stay atomic.
- Without the macro: the port is absent, there is no lock flag, and arbitration follows sel/RR every cycle.

Decomposition:
- Package bus_mux_pkg:
  - ARB_DIRECT=0, ARB_RR=1 constants.
  - clog2 function.
  - Default WIDTH=8.
- Sub-module rr_arbiter (N parameter): inputs req, ptr; outputs gnt_idx, gnt_ok. Purely combinational.
- Pointer register, output register and lock flag live in bus_mux_arb.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout; after release the first beat is from channel 0 (RR mode).
- Direct mode, N=4: sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2. Then sel=5 (N=6 build, ch5 invalid) -> no in_ready, out_valid drops.
- RR rotation, N=4, all valid, out_ready=1 -> out_chan sequence 0,1,2,3,0; with only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure: out_ready=0 after the first beat (8'h3C) -> out_data holds 8'h3C, in_ready=0, pointer frozen. Release out_ready -> next channel in RR order is accepted in that same cycle.
- Full throughput: 16 consecutive beats on ch0 with out_ready=1 -> out_valid stays high 16 cycles, no bubbles. Drop in_valid -> out_valid falls 1 cycle later.
- BUS_MUX_LOCK_EN, RR mode: ch2 sends 3 beats with in_lock=1,1,0 while ch0 and ch1 are valid -> out_chan=2,2,2, then 0. Assert rst mid-lock -> the next grant follows normal RR from channel 0.
